// File: rtl/spi_sample_responder.sv
// ---------------------------------------------------------------------------
// spi_sample_responder
//
// SPI mode-0 slave acting as the sample source of the moving-average filter's
// SPI link. Sample words pushed on the valid/ready port are buffered in a
// small FIFO. Each chip-select frame pops one word and shifts it out MSB-first
// on MISO. The MOSI bits received in the same frame are presented as a
// command word on rx_data_o, with a one-cycle rx_valid_o strobe.
//
// The SPI inputs are asynchronous to clk_i. They are synchronized, and every
// SPI event is detected as an edge of a synchronized signal. The master
// therefore has to keep sclk high and low for at least three clk periods.
//
// Optional build macro: SPI_RESPONDER_PARITY_EN
//   When defined, each frame is WIDTH+1 bits long.
//   - MISO appends an even-parity bit after the data LSB.
//   - The master's last MOSI bit is taken as its parity bit.
//   - A mismatch sets the sticky parity_err_o output, which underflow_clr_i
//     clears.
//
// Ports
//   clk_i, rst_i        system clock, synchronous active-high reset
//   sclk_i, cs_n_i      SPI clock / active-low chip select (asynchronous)
//   mosi_i              SPI data from the master
//   miso_o, miso_oe_o   SPI data to the master and its output enable
//   wr_data_i/valid_i   sample word to queue
//   wr_ready_o          FIFO can accept a word
//   rx_data_o/valid_o   last complete MOSI word, one-cycle update strobe
//   level_o             FIFO occupancy
//   underflow_o         sticky: a frame started with an empty FIFO
//   underflow_clr_i     clears underflow_o (and parity_err_o)
//   parity_err_o        sticky parity mismatch (parity build only)
// ---------------------------------------------------------------------------
module spi_sample_responder #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] IDLE_WORD   = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sclk_i,
    input  logic                       cs_n_i,
    input  logic                       mosi_i,
    output logic                       miso_o,
    output logic                       miso_oe_o,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    output logic [WIDTH-1:0]           rx_data_o,
    output logic                       rx_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
`ifdef SPI_RESPONDER_PARITY_EN
    output logic                       parity_err_o,
`endif
    output logic                       underflow_o,
    input  logic                       underflow_clr_i
);

`ifdef SPI_RESPONDER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers and edge detection
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    // cs_n resets to its idle (high) level so that leaving reset does not
    // look like a frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // -----------------------------------------------------------------------
    // Sample FIFO
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_ready_q;
    logic             push, pop, empty;
    state_t           state_q;

    assign empty = (level_q == '0);

    always_comb begin
        push    = wr_valid_i && wr_ready_q;
        pop     = (state_q == ST_IDLE) && cs_fall && !empty;
        level_d = level_q;
        if (push && !pop)
            level_d = level_q + LW'(1);
        else if (!push && pop)
            level_d = level_q - LW'(1);
    end

    // wr_ready is registered from the next level. When the FIFO is full, a
    // pop reopens it only from the following cycle, so a full FIFO never
    // accepts a write in the same cycle it pops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q    <= level_d;
            wr_ready_q <= (level_d != LW'(DEPTH));
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    logic [FRAME-1:0] tx_shreg_q, tx_load;
    logic [FRAME-2:0] rx_shreg_q;
    logic [FRAME-1:0] rx_next;
    logic [WIDTH-1:0] tx_word;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             underflow_q;
`ifdef SPI_RESPONDER_PARITY_EN
    logic             parity_err_q;
`endif

    assign tx_word = empty ? IDLE_WORD : mem_q[rd_ptr_q];
`ifdef SPI_RESPONDER_PARITY_EN
    // The even-parity bit rides behind the data LSB in the same shift register.
    assign tx_load = {tx_word, ^tx_word};
`else
    assign tx_load = tx_word;
`endif
    // Received bits including the one being captured on this sclk rise
    assign rx_next = {rx_shreg_q, mosi_s};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tx_shreg_q   <= '0;
            rx_shreg_q   <= '0;
            bit_cnt_q    <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underflow_q  <= 1'b0;
`ifdef SPI_RESPONDER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
            // Clear first; a set later in this block takes priority.
            if (underflow_clr_i) begin
                underflow_q  <= 1'b0;
`ifdef SPI_RESPONDER_PARITY_EN
                parity_err_q <= 1'b0;
`endif
            end
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        tx_shreg_q <= tx_load;
                        bit_cnt_q  <= '0;
                        if (empty) underflow_q <= 1'b1;
                        state_q    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        // Aborted frame: the popped word is dropped and
                        // rx_data is left untouched.
                        state_q <= ST_IDLE;
                    end else if (sclk_rise) begin
                        rx_shreg_q <= rx_next[FRAME-2:0];
                        bit_cnt_q  <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(FRAME - 1)) begin
                            state_q    <= ST_DONE;
                            rx_data_q  <= rx_next[FRAME-1 -: WIDTH];
                            rx_valid_q <= 1'b1;
`ifdef SPI_RESPONDER_PARITY_EN
                            // Data plus parity must XOR to zero.
                            if (^rx_next) parity_err_q <= 1'b1;
`endif
                        end
                    end else if (sclk_fall) begin
                        tx_shreg_q <= {tx_shreg_q[FRAME-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (cs_rise) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // MISO shows the shift register MSB only while a frame is shifting and
    // the pin is enabled. Outside a shifting frame (including DONE) it is 0.
    assign miso_oe_o    = ~cs_s;
    assign miso_o       = ~cs_s && (state_q == ST_SHIFT) && tx_shreg_q[FRAME-1];
    assign wr_ready_o   = wr_ready_q;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign level_o      = level_q;
    assign underflow_o  = underflow_q;
`ifdef SPI_RESPONDER_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

endmodule

// File: tb/tb_spi_sample_responder.sv
// Directed bench for spi_sample_responder (default build: 8-bit frames).
module tb_spi_sample_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic [7:0] wr_data = 8'h00;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] level;
    logic       underflow;
    logic       underflow_clr = 1'b0;
`ifdef SPI_RESPONDER_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0;

    spi_sample_responder #(
        .WIDTH(8), .DEPTH(4), .IDLE_WORD(8'h00), .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
        .miso_o(miso), .miso_oe_o(miso_oe),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .level_o(level),
`ifdef SPI_RESPONDER_PARITY_EN
        .parity_err_o(parity_err),
`endif
        .underflow_o(underflow), .underflow_clr_i(underflow_clr)
    );

    always #5 clk = ~clk;

    // Count rx_valid strobes (one count per high cycle).
    always @(negedge clk) if (rx_valid) rxv_cnt <= rxv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mode-0 frame, sclk period 8 clk. MISO is sampled just before each sclk
    // rise. nbits < 8 produces an aborted frame.
    task automatic spi_frame(input logic [7:0] mo, input int nbits,
                             output logic [7:0] mi, output logic oe);
        mi = 8'h00;
        oe = 1'b0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            repeat (4) @(negedge clk);
            mi = {mi[6:0], miso};
            if (i == 0) oe = miso_oe;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic write_word(input logic [7:0] d);
        @(negedge clk);
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] mi;
        logic       oe;
        int         rv0;
        logic [7:0] exp_q [4];

        // Reset held for two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_miso", miso, 1'b0);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_wr_ready", wr_ready, 1'b1);
        chk("rst_level", level, 3'd0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame
        write_word(8'hA5);
        chk("basic_level_pre", level, 3'd1);
        rv0 = rxv_cnt;
        spi_frame(8'h3C, 8, mi, oe);
        chk("basic_miso", mi, 8'hA5);
        chk("basic_oe_in_frame", oe, 1'b1);
        chk("basic_rx_data", rx_data, 8'h3C);
        chk("basic_rx_pulses", rxv_cnt - rv0, 1);
        chk("basic_level_post", level, 3'd0);
        chk("basic_oe_after", miso_oe, 1'b0);
        chk("basic_no_underflow", underflow, 1'b0);

        // FIFO full, fifth write dropped
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            wr_data  = 8'(i);
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        chk("full_level", level, 3'd4);
        chk("full_wr_ready", wr_ready, 1'b0);
        write_word(8'h05);
        chk("full_drop_level", level, 3'd4);
        for (int i = 1; i <= 4; i++) begin
            spi_frame(8'h5A, 8, mi, oe);
            chk($sformatf("full_pop%0d", i), mi, 8'(i));
        end
        chk("full_rx_data", rx_data, 8'h5A);
        chk("full_empty_level", level, 3'd0);
        chk("full_wr_ready_again", wr_ready, 1'b1);

        // Underflow and its clear
        rv0 = rxv_cnt;
        spi_frame(8'hC3, 8, mi, oe);
        chk("uflow_miso", mi, 8'h00);
        chk("uflow_flag", underflow, 1'b1);
        chk("uflow_rx_data", rx_data, 8'hC3);
        chk("uflow_rx_pulses", rxv_cnt - rv0, 1);
        @(negedge clk);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        chk("uflow_cleared", underflow, 1'b0);

        // Abort after 3 bits
        write_word(8'h11);
        write_word(8'h22);
        chk("abort_level_pre", level, 3'd2);
        rv0 = rxv_cnt;
        spi_frame(8'hFF, 3, mi, oe);
        chk("abort_first_bits", mi, 8'h00);
        chk("abort_no_rx_valid", rxv_cnt - rv0, 0);
        chk("abort_rx_data_kept", rx_data, 8'hC3);
        chk("abort_level", level, 3'd1);
        spi_frame(8'h96, 8, mi, oe);
        chk("abort_next_word", mi, 8'h22);
        chk("abort_next_rx", rx_data, 8'h96);
        chk("abort_level_post", level, 3'd0);

        // Pop while full with a write held pending
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wr_data  = 8'hA1 + 8'(i);
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_data = 8'hB0;
        chk("simul_level_full", level, 3'd4);
        chk("simul_wr_ready_low", wr_ready, 1'b0);
        spi_frame(8'h0F, 8, mi, oe);
        wr_valid = 1'b0;
        chk("simul_miso", mi, 8'hA1);
        chk("simul_level", level, 3'd4);
        chk("simul_wr_ready", wr_ready, 1'b0);
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB0};
        for (int i = 0; i < 4; i++) begin
            spi_frame(8'h00, 8, mi, oe);
            chk($sformatf("simul_drain%0d", i), mi, exp_q[i]);
        end
        chk("simul_level_end", level, 3'd0);
        chk("simul_no_underflow", underflow, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
